// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding scheduler for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Produces load-use stalls, branch flushes and registered EX operand-forward selects.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // A WB-stage producer resolves through the write-first regfile, so only the
  // EX and MEM slots carry state that can influence stalls or forwarding.
  logic              ex_v_q,  ex_v_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_wr_q, ex_wr_d;
  logic              ex_ld_q, ex_ld_d;
  logic              mem_v_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_wr_q;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic load_use;
  logic enter_ex;

  function automatic logic slot_writes(input logic              v,
                                       input logic              wr,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
    return v && wr && (rd == r) && (r != '0);
  endfunction

  // Nearest producer wins: EX/MEM result over MEM/WB result.
  function automatic logic [1:0] fwd_sel(input logic              rd_used,
                                         input logic [REG_AW-1:0] r,
                                         input logic              ex_hit_v,
                                         input logic              ex_hit_wr,
                                         input logic [REG_AW-1:0] ex_hit_rd,
                                         input logic              mem_hit_v,
                                         input logic              mem_hit_wr,
                                         input logic [REG_AW-1:0] mem_hit_rd);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rd_used) begin
      if (slot_writes(ex_hit_v, ex_hit_wr, ex_hit_rd, r)) begin
        sel = FWD_EXMEM;
      end else if (slot_writes(mem_hit_v, mem_hit_wr, mem_hit_rd, r)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    load_use = id_valid && ex_ld_q &&
               ((id_use_rs1 && slot_writes(ex_v_q, ex_wr_q, ex_rd_q, id_rs1)) ||
                (id_use_rs2 && slot_writes(ex_v_q, ex_wr_q, ex_rd_q, id_rs2)));

    flush_if_id = !rst && ex_br_taken;
    flush_id_ex = !rst && ex_br_taken;
    stall       = !rst && !ex_br_taken && load_use;
    enter_ex    = id_valid && !stall && !flush_id_ex;

    ex_v_d  = 1'b0;
    ex_rd_d = '0;
    ex_wr_d = 1'b0;
    ex_ld_d = 1'b0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (enter_ex) begin
      ex_v_d  = 1'b1;
      ex_rd_d = id_rd;
      ex_wr_d = id_wr_en;
      ex_ld_d = id_is_load;
      fwd_a_d = fwd_sel(id_use_rs1, id_rs1, ex_v_q, ex_wr_q, ex_rd_q,
                        mem_v_q, mem_wr_q, mem_rd_q);
      fwd_b_d = fwd_sel(id_use_rs2, id_rs2, ex_v_q, ex_wr_q, ex_rd_q,
                        mem_v_q, mem_wr_q, mem_rd_q);
    end

    cnt_d = stall ? sat_inc(cnt_q) : cnt_q;
  end

  // ID -> EX -> MEM slot advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      mem_wr_q <= ex_wr_q;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_fwd_ctrl;

  localparam int AW = 5;
  localparam int CW = 8;  // narrow counter keeps the saturation run short

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_wr_en, id_is_load;
  logic          ex_br_taken;
  logic          stall, flush_if_id, flush_id_ex;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  hazard_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            tag;
    logic          stall;
    logic          flush;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc_no  = 0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s cycle %0d: got %0h expected %0h", nm, tag, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall",       e.tag, 32'(stall),       32'(e.stall));
      chk("flush_if_id", e.tag, 32'(flush_if_id), 32'(e.flush));
      chk("flush_id_ex", e.tag, 32'(flush_id_ex), 32'(e.flush));
      chk("fwd_a",       e.tag, 32'(fwd_a),       32'(e.fa));
      chk("fwd_b",       e.tag, 32'(fwd_b),       32'(e.fb));
      chk("stall_cnt",   e.tag, 32'(stall_cnt),   32'(e.cnt));
    end
  end

  // One clock of stimulus; expectations describe what is visible during this cycle.
  task automatic cyc(input logic r, input logic v, input int rs1, input int rs2,
                     input logic u1, input logic u2, input int rd, input logic wr,
                     input logic ld, input logic br, input logic es, input logic ef,
                     input int fa, input int fb, input int cnt);
    exp_t e;
    rst = r; id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = AW'(rd); id_wr_en = wr;
    id_is_load = ld; ex_br_taken = br;
    e.tag = cyc_no; e.stall = es; e.flush = ef;
    e.fa = 2'(fa); e.fb = 2'(fb); e.cnt = CW'(cnt);
    sb.push_back(e);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int fa, input int fb, input int cnt);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_wr_en = 1'b0; id_is_load = 1'b0;
    ex_br_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      // reset state

    // ADD r3 followed directly by a user of r3 in rs1
    cyc(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0);

    // ADD r3, independent, user of r3 in rs2
    cyc(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 7, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 10, 3, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2, 0);

    // LW r5 then ADD using r5: one stall, then forward from MEM/WB
    cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 6, 1, 1, 12, 1, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 5, 6, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(2, 0, 1);

    // load to r0 followed by a consumer of r0
    cyc(0, 1, 1, 2, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 1);

    // load-use coinciding with a taken branch
    cyc(0, 1, 1, 2, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 6, 5, 1, 1, 14, 1, 0, 1, 0, 1, 0, 0, 1);
    cyc(0, 1, 6, 5, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 14, 0, 1, 0, 15, 1, 0, 0, 0, 0, 0, 2, 1);

    // build stall_cnt=7 and fwd_a=01, then reset
    cyc(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 1, 0, (i == 0) ? 0 : 2, 0, 1 + i);
      cyc(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 2 + i);
    end
    cyc(0, 1, 1, 0, 1, 0, 20, 1, 0, 0, 0, 0, 2, 0, 7);
    cyc(0, 1, 20, 0, 1, 0, 21, 1, 0, 0, 0, 0, 0, 0, 7);
    cyc(1, 1, 21, 0, 1, 0, 22, 1, 1, 1, 0, 0, 1, 0, 7);
    cyc(0, 1, 22, 21, 1, 1, 23, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);

    // saturation: 2^CW+3 stall cycles
    cyc(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      cyc(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 1, 0, (i == 0) ? 0 : 2, 0, (i > 255) ? 255 : i);
      cyc(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, (i + 1 > 255) ? 255 : i + 1);
    end
    idle(2, 0, 255);
    idle(0, 0, 255);

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
